f2d_reg: RTL and testbench
==========================

Name: f2d_reg

Overview:
- Fetch-to-decode pipeline register, directly downstream of the program counter and instruction memory.
- Captures the fetched PC and instruction each cycle and converts fetch faults into an exception code.
- Tracks the branch-delay-slot flag and supports hold (stall) and exception/interrupt flush.
- Keeps a retired-fetch counter for bring-up and performance debug.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into d_pc on reset.
- PC_HANDLER, 32'h0000_4180, value loaded into d_pc on a req flush.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LAST, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code for a fetch address fault.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all state; driven by the hazard unit.
- req  in  1  exception/interrupt flush from CP0; has priority over stall.
- f_pc  in  32  PC of the instruction currently in fetch.
- f_instr  in  32  instruction word read from instruction memory at f_pc.
- f_bd  in  1  fetched instruction is in a delay slot (decode-stage instruction is a branch or jump).
- d_pc  out  32  registered PC presented to decode.
- d_instr  out  32  registered instruction; 0 (nop) for bubbles and faults.
- d_exccode  out  5  registered exception code; 0 means none.
- d_bd  out  1  registered delay-slot flag.
- d_valid  out  1  1 = real fetched slot (including faulting slots); 0 = bubble.
- fetch_count  out  32  number of valid, non-faulting instructions latched so far.

Behaviour:
- Reset values (reset = 1 at a rising edge):
  - d_pc = PC_RESET; d_instr = 0; d_exccode = 0; d_bd = 0; d_valid = 0; fetch_count = 0.
  - reset overrides req and stall.
- Fault detect (combinational, on f_pc):
  - fault = (f_pc[1:0] != 0) OR (f_pc < IM_BASE) OR (f_pc > IM_LAST).
  - Comparisons are unsigned, 32-bit.
- Update priority per rising edge: reset > req > stall > load.
- req = 1 (flush):
  - d_pc = PC_HANDLER; d_instr = 0; d_exccode = 0; d_bd = 0; d_valid = 0.
  - fetch_count unchanged.
  - Applies even when stall = 1 in the same cycle.
- stall = 1, req = 0: every register holds its value, including fetch_count.
- Load (stall = 0, req = 0):
  - d_pc = f_pc; d_bd = f_bd; d_valid = 1.
  - If fault: d_instr = 0 and d_exccode = EXC_ADEL.
  - If no fault: d_instr = f_instr and d_exccode = 0.
  - fetch_count += 1 only on a load with no fault; wraps modulo 2^32 (0xFFFF_FFFF -> 0).
- Latency:
  - Outputs reflect inputs one cycle after a load edge.
  - No combinational path from any input to any output.
- Reset mid-stall or mid-flush: reset wins; the next edge behaves from the reset state.
- Faulting slots propagate with d_valid = 1 so that CP0 records the faulting PC as EPC.
- The faulting address itself is not latched; decode and CP0 reuse d_pc for BadVAddr.

Test Plan:
- Reset, then load f_pc=0x3000, f_instr=0x3C01_1234, f_bd=0 -> next edge: d_pc=0x3000, d_instr=0x3C01_1234, d_exccode=0, d_valid=1, fetch_count=1.
- Load f_pc=0x3004, then stall=1 for 3 cycles while f_pc steps to 0x3008/0x300C -> d_pc stays 0x3004, fetch_count stays constant; release stall -> d_pc=0x300C.
- f_pc=0x3002, then f_pc=0x7000, then f_pc=0x2FFC (each loaded) -> each: d_instr=0, d_exccode=4, d_valid=1; fetch_count unchanged; d_pc equals the faulting f_pc.
- stall=1 and req=1 together with f_pc=0x3010 -> d_pc=0x4180, d_instr=0, d_valid=0, d_bd=0; next load with f_bd=1, f_pc=0x4180 -> d_bd=1.
- Force fetch_count to 0xFFFF_FFFF via a preload sequence, then one good load -> fetch_count=0.
- reset=1 together with req=1 and stall=1 -> d_pc=0x3000, all other outputs 0.

Source files
------------

// File: rtl/f2d_reg.sv
// ---------------------------------------------------------------------------
// f2d_reg -- fetch-to-decode pipeline register
//
// This register sits between the program counter and instruction memory on
// one side and the decode stage on the other. It captures the fetched PC and
// instruction word and turns a bad fetch address into an exception code. It
// carries the branch-delay-slot flag forward and supports two controls:
// hold, which stalls the register, and flush, which is used for exceptions
// and interrupts. It also counts the good fetches it retires, which is
// useful during bring-up.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   stall        in   hold every register (hazard unit)
//   req          in   exception/interrupt flush from CP0; beats stall
//   f_pc         in   [31:0] PC of the instruction in fetch
//   f_instr      in   [31:0] instruction word read at f_pc
//   f_bd         in   fetched instruction sits in a delay slot
//   d_pc         out  [31:0] registered PC for decode
//   d_instr      out  [31:0] registered instruction (0 = nop on bubble/fault)
//   d_exccode    out  [4:0]  registered exception code (0 = none)
//   d_bd         out  registered delay-slot flag
//   d_valid      out  1 = real fetched slot (faults included), 0 = bubble
//   fetch_count  out  [31:0] valid, non-faulting loads so far (wraps)
//
// Parameters
//   COUNT_RESET sets the value fetch_count takes on reset. It defaults to 0.
//   A bring-up build can preload it to exercise the counter wrap.
// ---------------------------------------------------------------------------
module f2d_reg #(
    parameter logic [31:0] PC_RESET    = 32'h0000_3000,
    parameter logic [31:0] PC_HANDLER  = 32'h0000_4180,
    parameter logic [31:0] IM_BASE     = 32'h0000_3000,
    parameter logic [31:0] IM_LAST     = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL    = 5'd4,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_bd,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exccode,
    output logic        d_bd,
    output logic        d_valid,
    output logic [31:0] fetch_count
);

    // A fetch faults when it is misaligned or falls outside the instruction
    // memory window. All compares are 32-bit unsigned.
    logic fault;

    always_comb begin
        fault = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_LAST);
    end

    // Update priority: reset > req (flush) > stall (hold) > load.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments. Every register
        // then samples values from before the edge, which removes any
        // evaluation-order race with the neighbouring pipeline stages.
        if (reset) begin
            d_pc        <= PC_RESET;
            d_instr     <= 32'h0;
            d_exccode   <= 5'd0;
            d_bd        <= 1'b0;
            d_valid     <= 1'b0;
            fetch_count <= COUNT_RESET;
        end else if (req) begin
            // Flush: insert a bubble and point decode at the handler.
            // The retired-fetch count is left alone.
            d_pc      <= PC_HANDLER;
            d_instr   <= 32'h0;
            d_exccode <= 5'd0;
            d_bd      <= 1'b0;
            d_valid   <= 1'b0;
        end else if (!stall) begin
            // A faulting slot stays valid so that CP0 can take d_pc as the
            // EPC. The instruction is replaced by a nop.
            d_pc    <= f_pc;
            d_bd    <= f_bd;
            d_valid <= 1'b1;
            if (fault) begin
                d_instr   <= 32'h0;
                d_exccode <= EXC_ADEL;
            end else begin
                d_instr     <= f_instr;
                d_exccode   <= 5'd0;
                fetch_count <= fetch_count + 32'd1;
            end
        end
        // NOTE: if no branch assigns a register, it keeps its value. Inside a
        // clocked block this acts as a clock enable, so no latch is inferred.
    end

endmodule

// File: tb/tb_f2d_reg.sv
// ---------------------------------------------------------------------------
// tb_f2d_reg -- scoreboard bench for f2d_reg
//
// For each cycle the stimulus drives one directed vector on the falling edge.
// It also queues the values it expects after the next rising edge.
// A separate monitor pops one entry per rising edge and compares it with the
// outputs. A second instance has its counter preloaded to 0xFFFF_FFFF, so the
// first good load after reset shows the counter wrap.
// ---------------------------------------------------------------------------
module tb_f2d_reg;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
        logic [31:0] cnt;
        logic [31:0] cnt_wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, req, f_bd;
    logic [31:0] f_pc, f_instr;
    logic [31:0] d_pc, d_instr, fetch_count;
    logic [4:0]  d_exccode;
    logic        d_bd, d_valid;

    logic [31:0] w_pc, w_instr, w_count;
    logic [4:0]  w_exccode;
    logic        w_bd, w_valid;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    f2d_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req),
        .f_pc(f_pc), .f_instr(f_instr), .f_bd(f_bd),
        .d_pc(d_pc), .d_instr(d_instr), .d_exccode(d_exccode),
        .d_bd(d_bd), .d_valid(d_valid), .fetch_count(fetch_count)
    );

    f2d_reg #(.COUNT_RESET(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .req(req),
        .f_pc(f_pc), .f_instr(f_instr), .f_bd(f_bd),
        .d_pc(w_pc), .d_instr(w_instr), .d_exccode(w_exccode),
        .d_bd(w_bd), .d_valid(w_valid), .fetch_count(w_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and queue the state expected after
    // the following rising edge.
    task automatic step(input string name, input logic rst, input logic stl, input logic rq,
                        input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                        input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [4:0] e_exc,
                        input logic e_bd, input logic e_valid, input logic [31:0] e_cnt,
                        input logic [31:0] e_cnt_wrap);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; req = rq;
        f_pc = pc; f_instr = instr; f_bd = bd;
        e.name = name; e.pc = e_pc; e.instr = e_instr; e.exccode = e_exc;
        e.bd = e_bd; e.valid = e_valid; e.cnt = e_cnt; e.cnt_wrap = e_cnt_wrap;
        sb.push_back(e);
    endtask

    // Monitor: compare one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, ".d_pc"},      d_pc,               e.pc);
                check({e.name, ".d_instr"},   d_instr,            e.instr);
                check({e.name, ".d_exccode"}, {27'd0, d_exccode}, {27'd0, e.exccode});
                check({e.name, ".d_bd"},      {31'd0, d_bd},      {31'd0, e.bd});
                check({e.name, ".d_valid"},   {31'd0, d_valid},   {31'd0, e.valid});
                check({e.name, ".count"},     fetch_count,        e.cnt);
                check({e.name, ".wrap_count"}, w_count,           e.cnt_wrap);
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0;
        f_pc = 32'h0; f_instr = 32'h0; f_bd = 1'b0;

        //    name          rst stl req f_pc          f_instr       bd  | d_pc          d_instr       exc  bd  v   cnt wrap_cnt
        step("rst_all",     1,  1,  1,  32'h0000_3010, 32'h1111_1111, 1, 32'h0000_3000, 32'h0,        5'd0, 0, 0, 32'd0, 32'hFFFF_FFFF);
        step("load_3000",   0,  0,  0,  32'h0000_3000, 32'h3C01_1234, 0, 32'h0000_3000, 32'h3C01_1234, 5'd0, 0, 1, 32'd1, 32'd0);
        step("load_3004",   0,  0,  0,  32'h0000_3004, 32'h2402_0001, 0, 32'h0000_3004, 32'h2402_0001, 5'd0, 0, 1, 32'd2, 32'd1);
        step("stall1",      0,  1,  0,  32'h0000_3008, 32'hAAAA_AAAA, 1, 32'h0000_3004, 32'h2402_0001, 5'd0, 0, 1, 32'd2, 32'd1);
        step("stall2",      0,  1,  0,  32'h0000_300C, 32'h8C43_0004, 0, 32'h0000_3004, 32'h2402_0001, 5'd0, 0, 1, 32'd2, 32'd1);
        step("stall3",      0,  1,  0,  32'h0000_300C, 32'h8C43_0004, 0, 32'h0000_3004, 32'h2402_0001, 5'd0, 0, 1, 32'd2, 32'd1);
        step("release",     0,  0,  0,  32'h0000_300C, 32'h8C43_0004, 0, 32'h0000_300C, 32'h8C43_0004, 5'd0, 0, 1, 32'd3, 32'd2);
        step("misalign",    0,  0,  0,  32'h0000_3002, 32'hDEAD_BEEF, 0, 32'h0000_3002, 32'h0,        5'd4, 0, 1, 32'd3, 32'd2);
        step("above_last",  0,  0,  0,  32'h0000_7000, 32'hDEAD_BEEF, 0, 32'h0000_7000, 32'h0,        5'd4, 0, 1, 32'd3, 32'd2);
        step("below_base",  0,  0,  0,  32'h0000_2FFC, 32'hDEAD_BEEF, 1, 32'h0000_2FFC, 32'h0,        5'd4, 1, 1, 32'd3, 32'd2);
        step("at_last",     0,  0,  0,  32'h0000_6FFC, 32'h1000_FFFF, 1, 32'h0000_6FFC, 32'h1000_FFFF, 5'd0, 1, 1, 32'd4, 32'd3);
        step("flush_stall", 0,  1,  1,  32'h0000_3010, 32'h0123_4567, 1, 32'h0000_4180, 32'h0,        5'd0, 0, 0, 32'd4, 32'd3);
        step("handler_bd",  0,  0,  0,  32'h0000_4180, 32'h4200_0018, 1, 32'h0000_4180, 32'h4200_0018, 5'd0, 1, 1, 32'd5, 32'd4);
        step("top_addr",    0,  0,  0,  32'hFFFF_FFFC, 32'h5555_5555, 0, 32'hFFFF_FFFC, 32'h0,        5'd4, 0, 1, 32'd5, 32'd4);
        step("misalign1",   0,  0,  0,  32'h0000_3001, 32'h5555_5555, 0, 32'h0000_3001, 32'h0,        5'd4, 0, 1, 32'd5, 32'd4);
        step("rst_over",    1,  1,  1,  32'h0000_3014, 32'h7777_7777, 1, 32'h0000_3000, 32'h0,        5'd0, 0, 0, 32'd0, 32'hFFFF_FFFF);
        step("after_rst",   0,  0,  0,  32'h0000_3000, 32'h3C01_1234, 0, 32'h0000_3000, 32'h3C01_1234, 5'd0, 0, 1, 32'd1, 32'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
